adder_pipe: RTL

- Parametrised, pipelined add/subtract unit; successor to the 4-bit combinational adder_6.
- Splits a WIDTH-bit carry chain into CHUNK-bit slices, one register stage per slice. Accepts one operation per clock.
- Adds subtract mode, carry/overflow/zero flags and valid/ready handshakes on both sides.
- Sits between the operand-generation logic and the result display/checker in the lab datapath.

---
 rtl/adder_pipe_if.sv | 28 ++
 rtl/adder_pipe.sv | 108 ++++++++++
 2 files changed

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side drives operands and accepts results; the slave side is the adder itself.
interface adder_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             C4;
  logic             OF;
  logic             ZF;

  modport master (
    output in_valid, A, B, C0, sub, out_ready,
    input  in_ready, out_valid, F, C4, OF, ZF
  );

  modport slave (
    input  in_valid, A, B, C0, sub, out_ready,
    output in_ready, out_valid, F, C4, OF, ZF
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into CHUNK-bit slices, one register stage each.
// Unused operand slices ride ahead in skew registers; finished result slices accumulate so F leaves aligned.
module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int STAGES = WIDTH / CHUNK
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             of_q;
  logic             zf_q;

  // Subtraction is A + ~B + ~C0, so both operand inversions happen once at the input.
  assign b_eff = bus.B ^ {WIDTH{bus.sub}};
  assign c_eff = bus.C0 ^ bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                cin;
    logic                v_in;
    logic [CHUNK:0]      sum;
    logic [LO+CHUNK-1:0] f_d;
    logic [LO+CHUNK-1:0] f_q;
    logic                vld_q;
    logic                cry_q;

    if (k == 0) begin : g_src
      assign a_in = bus.A;
      assign b_in = b_eff;
      assign cin  = c_eff;
      assign v_in = bus.in_valid;
      assign f_d  = sum[CHUNK-1:0];
    end else begin : g_src
      assign a_in = g_stg[k-1].g_skew.a_rem;
      assign b_in = g_stg[k-1].g_skew.b_rem;
      assign cin  = g_stg[k-1].cry_q;
      assign v_in = g_stg[k-1].vld_q;
      assign f_d  = {sum[CHUNK-1:0], g_stg[k-1].f_q};
    end

    assign sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};

    // Bubbles shift exactly like data so every stage moves in lockstep on advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        f_q   <= '0;
      end else if (advance) begin
        vld_q <= v_in;
        cry_q <= sum[CHUNK];
        f_q   <= f_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_rem;
      logic [REM-CHUNK-1:0] b_rem;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (advance) begin
          a_rem <= a_in[REM-1:CHUNK];
          b_rem <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      logic msb_cin;
      assign msb_cin = sum[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          of_q <= 1'b0;
          zf_q <= 1'b0;
        end else if (advance) begin
          of_q <= msb_cin ^ sum[CHUNK];
          zf_q <= (f_d == '0);
        end
      end
    end
  end

  assign advance       = !g_stg[STAGES-1].vld_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.F         = g_stg[STAGES-1].f_q;
  assign bus.C4        = g_stg[STAGES-1].cry_q;
  assign bus.OF        = of_q;
  assign bus.ZF        = zf_q;

endmodule
